sprite_anime_sequencer: RTL and testbench
=========================================

SPRITE_ANIME_SEQUENCER -- requirements
Module: sprite_anime_sequencer

Interface
REQ-001 SHALL have parameter NUM_GHOSTS, default 4: number of ghost channels, range 1..15.
REQ-002 SHALL have parameter FRAME_DIV, default 8: i_tick pulses per animation step, range 1..255.
REQ-003 SHALL have parameter FLASH_DIV, default 16: i_tick pulses per frightened-flash toggle, range 1..255.
REQ-004 SHALL have parameter PAC_DIE_FRAMES, default 11: pacman death frame count, range 1..16.
REQ-005 SHALL have ports:
  i_clk  in  1  sole clock
  i_rst  in  1  asynchronous active-high reset
  i_tick  in  1  one-cycle frame pulse (vsync)
  i_pacman_moving  in  1  pacman advanced this frame
  i_pacman_direction  in  2  0 UP, 1 DOWN, 2 LEFT, 3 RIGHT
  i_pacman_die  in  1  one-cycle pulse: start death animation
  i_pacman_revive  in  1  one-cycle pulse: leave death animation
  i_ghost_state  in  4*NUM_GHOSTS  per-ghost G_* state code from params.vh, ghost k at [4k+3:4k]
  i_ghost_direction  in  2*NUM_GHOSTS  per-ghost direction, same encoding as pacman
  i_ghost_moving  in  NUM_GHOSTS  per-ghost moved this frame
  i_frightened_end  in  1  frightened mode about to expire
  i_which_char  in  4  1..NUM_GHOSTS selects ghost index (value-1)
  o_pacman_pose  out  5  pacman sprite index
  o_ghost_pose  out  4  selected ghost sprite index
  o_pacman_dying  out  1  high in DYING and DONE
  o_pacman_die_done  out  1  one-cycle pulse on death animation completion

Function
REQ-006 SHALL keep a shared prescaler div_cnt 0..FRAME_DIV-1, incremented on i_tick, wrapping to 0; step = i_tick AND div_cnt==FRAME_DIV-1.
REQ-007 SHALL keep a 2-bit chomp phase advancing by 1 mod 4 on step when i_pacman_moving=1 and FSM is NORMAL; held otherwise.
REQ-008 In NORMAL, pacman pose SHALL be: phase 0 -> dir; 1 -> dir+4; 2 -> 8; 3 -> dir+4.
REQ-009 Pacman FSM SHALL have states NORMAL, DYING, DONE; NORMAL->DYING on i_pacman_die, die_idx cleared to 0, chomp phase cleared to 0.
REQ-010 In DYING, die_idx SHALL advance by 1 on step; on step with die_idx==PAC_DIE_FRAMES-1 FSM SHALL go to DONE and o_pacman_die_done SHALL pulse exactly one cycle.
REQ-011 In DYING and DONE, pacman pose SHALL be 16+die_idx; DONE holds the last frame.
REQ-012 DONE->NORMAL SHALL occur only on i_pacman_revive; i_pacman_revive in NORMAL or DYING SHALL be ignored.
REQ-013 i_pacman_die SHALL be ignored in DYING and DONE; i_pacman_die coincident with step in NORMAL SHALL enter DYING with die_idx 0 (no chomp advance).
REQ-014 SHALL keep a per-ghost wiggle bit toggling on step when that ghost's i_ghost_moving=1.
REQ-015 Ghost pose SHALL be: G_IDLE/G_CHASE/G_SCATTER -> 2*dir+wiggle; G_FRIGHTENED -> 8+wiggle, or 10+wiggle when flash=1; G_DIE -> 12+dir; any other code -> 0.
REQ-016 o_ghost_pose SHALL present the ghost selected by i_which_char; i_which_char of 0 or >NUM_GHOSTS SHALL yield 0.
REQ-017 All outputs SHALL be registered: pose reflects inputs and state one i_clk cycle later.
REQ-018 Counter and state updates SHALL occur only on i_clk edges; no update without i_tick except FSM transitions on die/revive pulses.

Reset
REQ-019 i_rst SHALL asynchronously force: div_cnt 0, chomp phase 0, die_idx 0, FSM NORMAL, all wiggle bits 0, flash state 0, o_pacman_pose 0, o_ghost_pose 0, o_pacman_dying 0, o_pacman_die_done 0.
REQ-020 Reset asserted mid-DYING SHALL abort the animation with no o_pacman_die_done pulse.

Configuration
REQ-021 Macro ANIME_FLASH_EN defined: flash_cnt 0..FLASH_DIV-1 counts i_tick while i_frightened_end=1, flash bit toggles on wrap; i_frightened_end=0 clears flash_cnt and flash to 0 synchronously.
REQ-022 ANIME_FLASH_EN undefined: flash logic absent, flash constant 0, i_frightened_end ignored, frightened pose always 8+wiggle.

Verification
REQ-023 FRAME_DIV=8, moving=1, dir=RIGHT, 32 ticks -> pacman pose 3,7,8,7,3 changing every 8th tick.
REQ-024 moving=0 for 40 ticks after pose 7 -> pose stays 7; div_cnt still wraps.
REQ-025 die pulse in NORMAL, PAC_DIE_FRAMES=11 -> poses 16..26 each 8 ticks, one die_done pulse, 26 held; second die pulse ignored; revive -> pose = dir (phase 0).
REQ-026 Ghost 2 state G_FRIGHTENED, moving, i_which_char=3 -> pose 8/9 alternating; with ANIME_FLASH_EN, FLASH_DIV=16, frightened_end=1 -> pose 10/11 after 16 ticks, back to 8/9 after 32; G_DIE dir LEFT -> 14.
REQ-027 i_rst asserted while DYING at die_idx 5 -> all outputs 0 immediately, no die_done pulse; i_which_char=0 -> o_ghost_pose 0.

Source files
------------

// File: rtl/sprite_anime_sequencer.sv
// ----------------------------------------------------------------------------
// sprite_anime_sequencer
//
// Chooses which sprite frame to draw for pacman and for each ghost. All
// animation runs off i_tick (the vsync frame pulse). A shared prescaler
// divides i_tick down to an animation "step".
//
// Optional feature macro: ANIME_FLASH_EN
//   defined   : frightened ghosts flash (pose 10/11) while i_frightened_end
//               is high, toggling every FLASH_DIV ticks.
//   undefined : no flash logic; frightened pose is always 8+wiggle and
//               i_frightened_end is ignored.
//
// Ports
//   i_clk               sole clock
//   i_rst               asynchronous active-high reset
//   i_tick              one-cycle frame pulse
//   i_pacman_moving     pacman advanced this frame
//   i_pacman_direction  0 UP, 1 DOWN, 2 LEFT, 3 RIGHT
//   i_pacman_die        pulse: start death animation
//   i_pacman_revive     pulse: leave finished death animation
//   i_ghost_state       4 bits per ghost (ghost k at [4k+3:4k])
//   i_ghost_direction   2 bits per ghost
//   i_ghost_moving      1 bit per ghost
//   i_frightened_end    frightened mode about to expire
//   i_which_char        1..NUM_GHOSTS selects the ghost shown on o_ghost_pose
//   o_pacman_pose       pacman sprite index (registered)
//   o_ghost_pose        selected ghost sprite index (registered)
//   o_pacman_dying      high while the death animation runs or is held
//   o_pacman_die_done   one-cycle pulse when the death animation completes
//
// Ghost state codes mirror the game's params.vh:
//   G_IDLE=0, G_CHASE=1, G_SCATTER=2, G_FRIGHTENED=3, G_DIE=4.
// ----------------------------------------------------------------------------
module sprite_anime_sequencer #(
   parameter int NUM_GHOSTS     = 4,
   parameter int FRAME_DIV      = 8,
   parameter int FLASH_DIV      = 16,
   parameter int PAC_DIE_FRAMES = 11
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_tick,
   input  logic                      i_pacman_moving,
   input  logic [1:0]                i_pacman_direction,
   input  logic                      i_pacman_die,
   input  logic                      i_pacman_revive,
   input  logic [4*NUM_GHOSTS-1:0]   i_ghost_state,
   input  logic [2*NUM_GHOSTS-1:0]   i_ghost_direction,
   input  logic [NUM_GHOSTS-1:0]     i_ghost_moving,
   input  logic                      i_frightened_end,
   input  logic [3:0]                i_which_char,
   output logic [4:0]                o_pacman_pose,
   output logic [3:0]                o_ghost_pose,
   output logic                      o_pacman_dying,
   output logic                      o_pacman_die_done
);

   localparam logic [3:0] G_IDLE       = 4'd0;
   localparam logic [3:0] G_CHASE      = 4'd1;
   localparam logic [3:0] G_SCATTER    = 4'd2;
   localparam logic [3:0] G_FRIGHTENED = 4'd3;
   localparam logic [3:0] G_DIE        = 4'd4;

   localparam logic [7:0] FRAME_LAST = 8'(FRAME_DIV - 1);
   localparam logic [3:0] DIE_LAST   = 4'(PAC_DIE_FRAMES - 1);

   typedef enum logic [1:0] {
      NORMAL = 2'd0,
      DYING  = 2'd1,
      DONE   = 2'd2
   } pac_state_t;

   // ------------------------------------------------------------------
   // Shared prescaler
   // ------------------------------------------------------------------
   logic [7:0] div_cnt_reg;
   logic       step;

   assign step = i_tick && (div_cnt_reg == FRAME_LAST);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         div_cnt_reg <= 8'd0;
      end else if (i_tick) begin
         div_cnt_reg <= step ? 8'd0 : div_cnt_reg + 8'd1;
      end
   end

   // ------------------------------------------------------------------
   // Frightened flash
   // ------------------------------------------------------------------
   logic flash;

`ifdef ANIME_FLASH_EN
   localparam logic [7:0] FLASH_LAST = 8'(FLASH_DIV - 1);

   logic [7:0] flash_cnt_reg;
   logic       flash_reg;

   // Flash only runs while frightened mode is ending; dropping
   // i_frightened_end restarts the sequence from a steady (non-flash) pose.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         flash_cnt_reg <= 8'd0;
         flash_reg     <= 1'b0;
      end else if (!i_frightened_end) begin
         flash_cnt_reg <= 8'd0;
         flash_reg     <= 1'b0;
      end else if (i_tick) begin
         if (flash_cnt_reg == FLASH_LAST) begin
            flash_cnt_reg <= 8'd0;
            flash_reg     <= ~flash_reg;
         end else begin
            flash_cnt_reg <= flash_cnt_reg + 8'd1;
         end
      end
   end

   assign flash = flash_reg;
`else
   logic unused_frightened_end;

   assign flash                 = 1'b0;
   assign unused_frightened_end = i_frightened_end;
`endif

   // ------------------------------------------------------------------
   // Pacman FSM
   // ------------------------------------------------------------------
   pac_state_t state_reg, state_next;
   logic [1:0] phase_reg, phase_next;
   logic [3:0] die_idx_reg, die_idx_next;
   logic       die_done_next;
   logic [4:0] pac_pose_next;
   logic [4:0] dir_ext;

   assign dir_ext = {3'b000, i_pacman_direction};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg   <= NORMAL;
         phase_reg   <= 2'd0;
         die_idx_reg <= 4'd0;
      end else begin
         state_reg   <= state_next;
         phase_reg   <= phase_next;
         die_idx_reg <= die_idx_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      phase_next    = phase_reg;
      die_idx_next  = die_idx_reg;
      die_done_next = 1'b0;
      pac_pose_next = 5'd16 + {1'b0, die_idx_reg};

      case (state_reg)
         NORMAL: begin
            // A die pulse wins over a coincident chomp step.
            if (i_pacman_die) begin
               state_next   = DYING;
               die_idx_next = 4'd0;
               phase_next   = 2'd0;
            end else if (step && i_pacman_moving) begin
               phase_next = phase_reg + 2'd1;
            end

            case (phase_reg)
               2'd0:    pac_pose_next = dir_ext;
               2'd2:    pac_pose_next = 5'd8;
               default: pac_pose_next = dir_ext + 5'd4;
            endcase
         end

         DYING: begin
            if (step) begin
               if (die_idx_reg == DIE_LAST) begin
                  state_next    = DONE;
                  die_done_next = 1'b1;
               end else begin
                  die_idx_next = die_idx_reg + 4'd1;
               end
            end
         end

         DONE: begin
            // Last death frame is held until the game revives pacman.
            if (i_pacman_revive) begin
               state_next = NORMAL;
            end
         end

         default: begin
            state_next = NORMAL;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Ghost channels
   // ------------------------------------------------------------------
   logic [3:0] ghost_pose_each [NUM_GHOSTS];
   logic [3:0] ghost_sel;

   generate
      for (genvar gi = 0; gi < NUM_GHOSTS; gi++) begin : g_ghost
         logic       wiggle_reg;
         logic [3:0] code;
         logic [1:0] dir;
         logic [3:0] pose;

         assign code = i_ghost_state[4*gi +: 4];
         assign dir  = i_ghost_direction[2*gi +: 2];

         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               wiggle_reg <= 1'b0;
            end else if (step && i_ghost_moving[gi]) begin
               wiggle_reg <= ~wiggle_reg;
            end
         end

         // Sprite sheet: 0..7 walking (2 per direction), 8/9 frightened,
         // 10/11 frightened flashing, 12..15 eyes-only per direction.
         always_comb begin
            pose = 4'd0;
            case (code)
               G_IDLE, G_CHASE, G_SCATTER: pose = {1'b0, dir, wiggle_reg};
               G_FRIGHTENED:               pose = {2'b10, flash, wiggle_reg};
               G_DIE:                      pose = {2'b11, dir};
               default:                    pose = 4'd0;
            endcase
         end

         assign ghost_pose_each[gi] = pose;
      end
   endgenerate

   // Out-of-range selectors (0 or above NUM_GHOSTS) fall through to 0.
   always_comb begin
      ghost_sel = 4'd0;
      for (int k = 0; k < NUM_GHOSTS; k++) begin
         if (i_which_char == 4'(k + 1)) begin
            ghost_sel = ghost_pose_each[k];
         end
      end
   end

   // ------------------------------------------------------------------
   // Output registers
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_pacman_pose     <= 5'd0;
         o_ghost_pose      <= 4'd0;
         o_pacman_dying    <= 1'b0;
         o_pacman_die_done <= 1'b0;
      end else begin
         o_pacman_pose     <= pac_pose_next;
         o_ghost_pose      <= ghost_sel;
         o_pacman_dying    <= (state_reg != NORMAL);
         o_pacman_die_done <= die_done_next;
      end
   end

endmodule

// File: tb/tb_sprite_anime_sequencer.sv
// ----------------------------------------------------------------------------
// tb_sprite_anime_sequencer
//
// Directed stimulus drives the sequencer; each expectation is pushed into a
// scoreboard queue and a separate monitor compares it against the DUT on the
// following falling clock edge. Death-done pulses are counted continuously.
// ----------------------------------------------------------------------------
module tb_sprite_anime_sequencer;

`ifdef ANIME_FLASH_EN
   localparam bit FL = 1'b1;
`else
   localparam bit FL = 1'b0;
`endif

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_tick;
   logic        i_pacman_moving;
   logic [1:0]  i_pacman_direction;
   logic        i_pacman_die;
   logic        i_pacman_revive;
   logic [15:0] i_ghost_state;
   logic [7:0]  i_ghost_direction;
   logic [3:0]  i_ghost_moving;
   logic        i_frightened_end;
   logic [3:0]  i_which_char;
   logic [4:0]  o_pacman_pose;
   logic [3:0]  o_ghost_pose;
   logic        o_pacman_dying;
   logic        o_pacman_die_done;

   sprite_anime_sequencer #(
      .NUM_GHOSTS(4), .FRAME_DIV(8), .FLASH_DIV(16), .PAC_DIE_FRAMES(11)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_tick(i_tick),
      .i_pacman_moving(i_pacman_moving), .i_pacman_direction(i_pacman_direction),
      .i_pacman_die(i_pacman_die), .i_pacman_revive(i_pacman_revive),
      .i_ghost_state(i_ghost_state), .i_ghost_direction(i_ghost_direction),
      .i_ghost_moving(i_ghost_moving), .i_frightened_end(i_frightened_end),
      .i_which_char(i_which_char), .o_pacman_pose(o_pacman_pose),
      .o_ghost_pose(o_ghost_pose), .o_pacman_dying(o_pacman_dying),
      .o_pacman_die_done(o_pacman_die_done)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [4:0]  pac;
      logic [3:0]  ghost;
      logic        dying;
      int unsigned done_cnt;
   } exp_t;

   exp_t        exp_q [$];
   string       name_q [$];
   int unsigned done_cnt = 0;
   int          checks = 0;
   int          passed = 0;

   // Count completion pulses for the whole run.
   always @(negedge i_clk) begin
      if (o_pacman_die_done === 1'b1) done_cnt++;
   end

   // Scoreboard monitor.
   always @(negedge i_clk) begin
      if (exp_q.size() != 0) begin
         exp_t  e;
         string n;
         e = exp_q.pop_front();
         n = name_q.pop_front();
         checks++;
         if (o_pacman_pose !== e.pac || o_ghost_pose !== e.ghost ||
             o_pacman_dying !== e.dying || o_pacman_die_done !== 1'b0 ||
             done_cnt != e.done_cnt) begin
            $display("FAIL %s: got pac=%0d ghost=%0d dying=%0d done=%0d done_cnt=%0d, want pac=%0d ghost=%0d dying=%0d done=0 done_cnt=%0d",
                     n, o_pacman_pose, o_ghost_pose, o_pacman_dying, o_pacman_die_done,
                     done_cnt, e.pac, e.ghost, e.dying, e.done_cnt);
         end else begin
            passed++;
            $display("check %s: pac=%0d ghost=%0d dying=%0d done_cnt=%0d ok",
                     n, o_pacman_pose, o_ghost_pose, o_pacman_dying, done_cnt);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", passed, checks);
      $fatal(1);
   end

   task automatic expect_out(input string name, input int pac, input int ghost,
                             input bit dying, input int unsigned dcnt);
      exp_t e;
      e.pac      = 5'(pac);
      e.ghost    = 4'(ghost);
      e.dying    = dying;
      e.done_cnt = dcnt;
      exp_q.push_back(e);
      name_q.push_back(name);
      @(posedge i_clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge i_clk); #1; end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         i_tick = 1'b1;
         @(posedge i_clk); #1;
         i_tick = 1'b0;
         @(posedge i_clk); #1;
      end
   endtask

   task automatic pulse_die();
      i_pacman_die = 1'b1;
      @(posedge i_clk); #1;
      i_pacman_die = 1'b0;
      @(posedge i_clk); #1;
   endtask

   task automatic pulse_revive();
      i_pacman_revive = 1'b1;
      @(posedge i_clk); #1;
      i_pacman_revive = 1'b0;
      @(posedge i_clk); #1;
   endtask

   int pac_seq [5]   = '{3, 7, 8, 7, 3};
   int ghost_seq [5] = '{8, 9, 8, 9, 8};
   int wc_tab [6]    = '{1, 2, 4, 5, 15, 0};
   int gp_tab [6]    = '{4, 14, 2, 0, 0, 0};

   initial begin
      i_rst = 1'b1; i_tick = 1'b0; i_pacman_moving = 1'b0; i_pacman_direction = 2'd0;
      i_pacman_die = 1'b0; i_pacman_revive = 1'b0; i_ghost_state = 16'd0;
      i_ghost_direction = 8'd0; i_ghost_moving = 4'd0; i_frightened_end = 1'b0;
      i_which_char = 4'd0;
      idle(3);
      expect_out("reset_state", 0, 0, 1'b0, 0);

      // g0 CHASE/LEFT, g1 DIE/LEFT, g2 FRIGHTENED, g3 SCATTER/DOWN
      i_pacman_direction = 2'd3;
      i_pacman_moving    = 1'b1;
      i_ghost_state      = {4'd2, 4'd3, 4'd4, 4'd1};
      i_ghost_direction  = {2'd1, 2'd0, 2'd2, 2'd2};
      i_ghost_moving     = 4'b0100;
      i_which_char       = 4'd3;
      i_rst              = 1'b0;
      idle(2);
      expect_out("after_reset", 3, 8, 1'b0, 0);

      // Chomp cycle, one step every 8th tick.
      for (int s = 0; s < 4; s++) begin
         ticks(7);
         expect_out($sformatf("chomp_hold%0d", s), pac_seq[s], ghost_seq[s], 1'b0, 0);
         ticks(1);
         expect_out($sformatf("chomp_step%0d", s), pac_seq[s+1], ghost_seq[s+1], 1'b0, 0);
      end

      // Not moving: pose held, prescaler keeps wrapping.
      ticks(8);
      expect_out("to_pose7", 7, 9, 1'b0, 0);
      i_pacman_moving = 1'b0;
      ticks(40);
      expect_out("still_40", 7, 8, 1'b0, 0);
      i_pacman_moving = 1'b1;
      ticks(7);
      expect_out("resume_hold", 7, 8, 1'b0, 0);
      ticks(1);
      expect_out("resume_step", 8, 9, 1'b0, 0);

      // Ghost selection and pose codes.
      for (int k = 0; k < 6; k++) begin
         i_which_char = 4'(wc_tab[k]);
         idle(1);
         expect_out($sformatf("ghost_sel%0d", wc_tab[k]), 8, gp_tab[k], 1'b0, 0);
      end
      i_ghost_state[15:12] = 4'd9;
      i_which_char = 4'd4;
      idle(1);
      expect_out("ghost_bad_code", 8, 0, 1'b0, 0);
      i_which_char = 4'd3;
      idle(1);
      expect_out("ghost_back3", 8, 9, 1'b0, 0);

      // Frightened flash.
      i_pacman_moving  = 1'b0;
      i_frightened_end = 1'b1;
      ticks(15);
      expect_out("flash_pre", 8, 8, 1'b0, 0);
      ticks(1);
      expect_out("flash_on", 8, FL ? 11 : 9, 1'b0, 0);
      ticks(16);
      expect_out("flash_off", 8, 9, 1'b0, 0);
      ticks(16);
      expect_out("flash_on2", 8, FL ? 11 : 9, 1'b0, 0);
      i_frightened_end = 1'b0;
      idle(2);
      expect_out("flash_clear", 8, 9, 1'b0, 0);

      // Death animation.
      i_pacman_moving = 1'b1;
      i_ghost_moving  = 4'b0000;
      pulse_die();
      expect_out("die_start", 16, 9, 1'b1, 0);
      for (int i = 1; i <= 10; i++) begin
         ticks(8);
         if (i == 3) begin
            pulse_revive();
            pulse_die();
         end
         expect_out($sformatf("die_frame%0d", i), 16 + i, 9, 1'b1, 0);
      end
      ticks(8);
      expect_out("die_done", 26, 9, 1'b1, 1);
      ticks(16);
      expect_out("done_hold", 26, 9, 1'b1, 1);
      pulse_die();
      expect_out("done_die_ignored", 26, 9, 1'b1, 1);
      pulse_revive();
      expect_out("revive", 3, 9, 1'b0, 1);

      // Die coincident with a step, then reset mid-animation.
      ticks(7);
      expect_out("pre_coincident", 3, 9, 1'b0, 1);
      i_tick = 1'b1; i_pacman_die = 1'b1;
      @(posedge i_clk); #1;
      i_tick = 1'b0; i_pacman_die = 1'b0;
      @(posedge i_clk); #1;
      expect_out("die_on_step", 16, 9, 1'b1, 1);
      ticks(40);
      expect_out("die_idx5", 21, 9, 1'b1, 1);
      i_rst = 1'b1;
      expect_out("async_reset", 0, 0, 1'b0, 1);
      idle(3);
      i_ghost_moving = 4'b0100;
      i_rst = 1'b0;
      idle(1);
      expect_out("post_reset", 3, 8, 1'b0, 1);
      ticks(48);
      expect_out("post_reset_run", 8, 8, 1'b0, 1);

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge i_clk);
      if (exp_q.size() != 0) begin
         checks++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
